// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: FSM encoding, iteration count
// and the HI/LO field layout of the 64-bit result.
package div_defs;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    CALC   = 2'b01,
    FINISH = 2'b10
  } div_state_e;

  localparam int DIV_WIDTH  = 32;
  localparam int DIV_CYCLES = DIV_WIDTH;

  localparam int HI_MSB = 2*DIV_WIDTH-1;
  localparam int HI_LSB = DIV_WIDTH;
  localparam int LO_MSB = DIV_WIDTH-1;
  localparam int LO_LSB = 0;

endpackage

// File: rtl/div_unit_step.sv
// One restoring shift-subtract iteration: shift {rem, quo} left by one,
// trial-subtract the divisor and keep the difference when it is non-negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // The partial remainder stays below the divisor, so WIDTH+1 bits never overflow
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    diff    = shifted - {1'b0, dvsr_i};
    rem_o   = shifted[WIDTH-1:0];
    quo_o   = {quo_i[WIDTH-2:0], 1'b0};
    if (!diff[WIDTH]) begin
      rem_o = diff[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit: magnitude restoring division over WIDTH cycles,
// sign correction on the last step, pipeline stall while busy.
module div_unit
  import div_defs::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  input  logic               annul,
  output logic               div_stall,
  output logic               result_valid,
  output logic [2*WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH-1);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  div_state_e         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   rem_q, quo_q, dvsr_q;
  logic               qneg_q, rneg_q;
  logic [2*WIDTH-1:0] result_q;
  logic               valid_q;
  logic [WIDTH-1:0]   rem_d, quo_d;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + ONE;
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic           sgn);
    return (sgn && v[WIDTH-1]) ? negate(v) : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                  input logic           neg);
    return neg ? negate(v) : v;
  endfunction

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvsr_i(dvsr_q),
    .rem_o (rem_d),
    .quo_o (quo_d)
  );

  // result is registered on entry to FINISH so it is visible with the valid pulse
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (annul) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              if (divisor == '0) begin
                result_q <= {dividend, {WIDTH{1'b1}}};
                valid_q  <= 1'b1;
                state_q  <= FINISH;
              end else begin
                rem_q   <= '0;
                quo_q   <= magnitude(dividend, is_signed);
                dvsr_q  <= magnitude(divisor, is_signed);
                qneg_q  <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                rneg_q  <= is_signed && dividend[WIDTH-1];
                cnt_q   <= '0;
                state_q <= CALC;
              end
            end
          end
          CALC: begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_STEP) begin
              result_q <= {apply_sign(rem_d, rneg_q), apply_sign(quo_d, qneg_q)};
              valid_q  <= 1'b1;
              state_q  <= FINISH;
            end
          end
          FINISH:  state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign div_stall    = ((state_q == IDLE) && start && !annul) || (state_q == CALC);
  assign result_valid = valid_q;
  assign result       = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: vector table plus hand-written
// annul / reset / ignored-start sequences, scoreboard of expected results.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        annul;
  logic        div_stall;
  logic        result_valid;
  logic [63:0] result;

  int checks = 0;
  int errors = 0;

  logic [63:0] sb[$];
  logic [63:0] prev_result;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    int          lat;
  } vec_t;

  vec_t tbl[11];

  div_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .annul       (annul),
    .div_stall   (div_stall),
    .result_valid(result_valid),
    .result      (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives a request at the current negedge (cycle 0 of the operation).
  task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input bit push);
    start     = 1'b1;
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    if (push) sb.push_back(exp);
    #1;
    check("stall_cycle0", {63'd0, div_stall}, 64'd1);
  endtask

  // Polls from cycle 1 until result_valid; checks latency, stall and data.
  task automatic await_result(input int lat, input bit hold_start);
    int c = 0;
    bit got = 0;
    bit stall_ok = 1;
    logic [63:0] exp;
    while (c < 80 && !got) begin
      @(negedge clk);
      c++;
      if (c == 1) begin
        start    = hold_start;
        dividend = hold_start ? 32'd1 : $urandom;
        divisor  = hold_start ? 32'd1 : $urandom;
      end
      if (result_valid) got = 1;
      else if (!div_stall) stall_ok = 0;
    end
    start = 1'b0;
    check("valid_seen", {63'd0, got}, 64'd1);
    if (got) begin
      check("latency", 64'(c), 64'(lat));
      check("stall_low_finish", {63'd0, div_stall}, 64'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: got result 0x%0h with no expectation", result);
      end else begin
        exp = sb.pop_front();
        check("result", result, exp);
        prev_result = exp;
      end
    end
    check("stall_during_calc", {63'd0, stall_ok}, 64'd1);
  endtask

  initial begin
    tbl[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33};
    tbl[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   33};
    tbl[2]  = '{1'b0, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC,   32'd1,          33};
    tbl[3]  = '{1'b1, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1};
    tbl[4]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          33};
    tbl[5]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          33};
    tbl[6]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          33};
    tbl[7]  = '{1'b0, 32'd0,          32'd5,          32'd0,          32'd0,          33};
    tbl[8]  = '{1'b1, 32'hFFFFFF9C,   32'd0,          32'hFFFFFFFF,   32'hFFFFFF9C,   1};
    tbl[9]  = '{1'b1, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   33};
    tbl[10] = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3,          33};

    resetn = 1'b0; start = 1'b0; is_signed = 1'b0;
    dividend = '0; divisor = '0; annul = 1'b0;
    prev_result = '0;
    repeat (3) @(negedge clk);
    check("reset_result", result, 64'd0);
    check("reset_valid", {63'd0, result_valid}, 64'd0);
    check("reset_stall", {63'd0, div_stall}, 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      issue(tbl[i].sgn, tbl[i].a, tbl[i].b, {tbl[i].hi, tbl[i].lo}, 1'b1);
      await_result(tbl[i].lat, 1'b0);
      @(negedge clk);
      check("valid_pulse", {63'd0, result_valid}, 64'd0);
      check("result_hold", result, prev_result);
    end

    for (int i = 0; i < 4; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom >> (i * 8);
      if (b == 0) b = 32'd3;
      issue(1'b0, a, b, {a % b, a / b}, 1'b1);
      await_result(33, 1'b0);
      @(negedge clk);
    end

    // annul at cycle 10 of 1000/3, then 9/3 starting at cycle 11
    begin
      bit seen = 0;
      issue(1'b0, 32'd1000, 32'd3, 64'd0, 1'b0);
      for (int c = 1; c <= 10; c++) begin
        @(negedge clk);
        if (c == 1) start = 1'b0;
        if (result_valid) seen = 1;
        if (c == 10) annul = 1'b1;
      end
      @(negedge clk);
      annul = 1'b0;
      #1;
      check("annul_no_valid", {63'd0, seen | result_valid}, 64'd0);
      check("annul_result_hold", result, prev_result);
      check("annul_idle_stall", {63'd0, div_stall}, 64'd0);
      issue(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b1);
      await_result(33, 1'b0);
      @(negedge clk);
    end

    // start held high during CALC is ignored
    issue(1'b0, 32'd200, 32'd9, {32'd2, 32'd22}, 1'b1);
    await_result(33, 1'b1);
    @(negedge clk);
    check("ignored_start_no_extra", {63'd0, result_valid}, 64'd0);

    // reset at cycle 15 of an operation
    issue(1'b1, 32'd50, 32'd5, {32'd0, 32'd10}, 1'b1);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    resetn = 1'b0;
    @(negedge clk);
    check("midop_reset_result", result, 64'd0);
    check("midop_reset_valid", {63'd0, result_valid}, 64'd0);
    check("midop_reset_stall", {63'd0, div_stall}, 64'd0);
    sb.delete();
    resetn = 1'b1;
    repeat (40) @(negedge clk);
    check("post_reset_quiet", {63'd0, result_valid}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
